// File: rtl/wbu.sv
// ---------------------------------------------------------------------------
// wbu -- write-back unit, the last stage of the multi-cycle core.
//
// It takes one packet per instruction from the load/store stage, picks either
// the load data or the execute result, and writes that value to the register
// file once. Writes to x0 are suppressed. It then signals completion to the
// fetch stage and waits until fetch accepts it. Only one instruction is ever
// in flight.
//
// Ports:
//   clk        core clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   lsu_valid  upstream packet valid
//   lsu_data   packet {load[W], rd[5], reg_wen, sel_mem, result[W]}
//   wbu_ready  unit is idle and can accept a packet this cycle
//   rf_wen     register-file write enable, single-cycle pulse
//   rf_waddr   destination register index
//   rf_wdata   register write data
//   wbu_valid  instruction complete, next fetch may start
//   ifu_ready  fetch stage accepts the completion
//   retire_cnt 64-bit count of completion handshakes
//              (only present when WBU_RETIRE_CNT_EN is defined)
//
// Optional feature macro: WBU_RETIRE_CNT_EN
// ---------------------------------------------------------------------------
module wbu #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               lsu_valid,
   input  logic [2*WIDTH+6:0] lsu_data,
   output logic               wbu_ready,
   output logic               rf_wen,
   output logic [4:0]         rf_waddr,
   output logic [WIDTH-1:0]   rf_wdata,
   output logic               wbu_valid,
   input  logic               ifu_ready
`ifdef WBU_RETIRE_CNT_EN
   ,
   output logic [63:0]        retire_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] pkt_load;
   logic [4:0]       pkt_rd;
   logic             pkt_reg_wen;
   logic             pkt_sel_mem;
   logic [WIDTH-1:0] pkt_result;
   logic             transfer;

   // Packet field extraction, only meaningful on a transfer edge.
   assign pkt_load    = lsu_data[2*WIDTH+6 -: WIDTH];
   assign pkt_rd      = lsu_data[WIDTH+6 -: 5];
   assign pkt_reg_wen = lsu_data[WIDTH+1];
   assign pkt_sel_mem = lsu_data[WIDTH];
   assign pkt_result  = lsu_data[WIDTH-1:0];

   // Ready depends on the state register alone, so there is no combinational
   // path from lsu_valid back to wbu_ready.
   assign wbu_ready = (state == S_IDLE);
   assign transfer  = lsu_valid & wbu_ready;

   // Next-state logic. S_WRITE lasts exactly one cycle; if fetch is not ready
   // yet we park in S_DONE until it is. Unknown encodings fall back to idle.
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (transfer) state_next = S_WRITE;
         S_WRITE: state_next = ifu_ready ? S_IDLE : S_DONE;
         S_DONE:  if (ifu_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State and registered outputs. The address/data registers double as the
   // captured packet: they load only on a transfer and hold through S_DONE.
   // rf_wen and wbu_valid are registered images of the state being entered,
   // so they line up with S_WRITE / S_WRITE+S_DONE without decode glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rf_wen    <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         wbu_valid <= 1'b0;
      end else begin
         state     <= state_next;
         rf_wen    <= 1'b0;
         wbu_valid <= (state_next == S_WRITE) || (state_next == S_DONE);
         if (transfer) begin
            rf_wen   <= pkt_reg_wen & (pkt_rd != 5'd0);
            rf_waddr <= pkt_rd;
            rf_wdata <= pkt_sel_mem ? pkt_load : pkt_result;
         end
      end
   end

`ifdef WBU_RETIRE_CNT_EN
   // Counts every completion handshake, including instructions with no
   // register write. Wraps naturally at 2^64.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt <= 64'd0;
      end else if (wbu_valid && ifu_ready) begin
         retire_cnt <= retire_cnt + 64'd1;
      end
   end
`endif

endmodule
